stein_mod_inverse: RTL
======================

Name: stein_mod_inverse

Overview:
- Clocked binary (Stein-style) extended-GCD engine computing the modular inverse R = P^-1 mod Q. It is the inverse-direction companion to the combinational Stein GCD block.
- Same P/Q/R operand naming; adds a start/done handshake so it sits behind a controller or bench driver.
- One micro-operation per clock using shift/subtract only, with no multiplier or divider.

Parameters:
- W, 8, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- P  input  W  value to invert; latched on accepted start.
- Q  input  W  modulus; latched on accepted start.
- R  output  W  inverse, in range [1, Q-1]; 0 when valid=0.
- valid  output  1  1 = inverse exists; qualifies R.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  single-cycle pulse when R/valid are updated.

Behaviour:
- Reset: state=IDLE; R=0, valid=0, busy=0, done=0; internal u, v, x1, x2 cleared. Reset mid-operation aborts at the next edge with no done pulse.
- Accept: start=1 in IDLE latches P and Q. start while busy or during the done cycle is ignored and not queued.
- Registers:
  - u, v, x1, x2 are W bits.
  - Intermediate x+Q is W+1 bits.
  - All x arithmetic stays in [0, Q-1].
- States and transitions:
  - IDLE -> CHECK on start.
  - CHECK (1 cycle): if Q even or Q<3, go to FINISH with valid=0. Else u=P, v=Q, x1=1, x2=0, go to REDUCE.
  - REDUCE: if u>=Q then u=u-Q, stay; else go to LOOP. At most 85 cycles for W=8.
  - LOOP, one action per cycle, priority order:
    - (a) u==1: go to FINISH, R=x1, valid=1.
    - (b) v==1: go to FINISH, R=x2, valid=1.
    - (c) u==0: go to FINISH, valid=0 (gcd≠1).
    - (d) u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+Q)>>1.
    - (e) v even: v=v>>1; same rule applied to x2.
    - (f) u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+Q-x2.
    - (g) else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+Q-x1.
  - FINISH: drive R/valid, done=1 for one cycle, busy=0, return to IDLE.
- Output hold: R and valid hold until the next accepted start's FINISH. They do not clear at start.
- Boundary cases:
  - P=0 -> valid=0.
  - P=1 -> R=1.
  - P>=Q is reduced first.
  - P=Q -> u reduces to 0 -> valid=0.
  - Q even, including Q=0 -> valid=0 within 3 cycles of start.
- Latency: worst case is bounded by REDUCE plus 4*W LOOP cycles. The bench timeout is 200 cycles for W=8.

Optional Feature:
- Macro STEIN_INV_CYCLES_EN.
- Defined: adds output port cycles [15:0]. It counts clocks from the CHECK entry through FINISH, inclusive. It loads on FINISH, holds until the next FINISH, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package stein_pkg holds:
  - the state enum (IDLE, CHECK, REDUCE, LOOP, FINISH);
  - the default width constant 8;
  - the bench timeout constant 200.
- One sub-module, stein_halve_mod: combinational (x even ? x>>1 : (x+Q)>>1), W+1-bit internal. It is instantiated twice, for x1 and x2.

Test Plan:
- P=3, Q=7, start -> done pulse, R=5, valid=1. busy is high between start and done.
- P=10, Q=17 -> R=12, valid=1. P=200, Q=251 -> R=187, valid=1.
- P=6, Q=9 (gcd 3) -> R=0, valid=0. P=0, Q=7 -> valid=0. P=4, Q=8 (even) -> valid=0 within 3 cycles.
- P=20, Q=7 (P>Q) -> R=6 (20≡6, 6*6=36≡1). P=1, Q=251 -> R=1. P=250, Q=251 -> R=250.
- start re-asserted while busy with P=2, Q=5 -> ignored; the original result is delivered, with exactly one done pulse.
- rst=1 for one cycle mid-LOOP -> next cycle busy=0, R=0, valid=0, no done pulse. A new start then completes normally.

Source files
------------

// File: rtl/stein_pkg.sv
// Shared definitions for the Stein modular-inverse engine: FSM state encoding,
// default operand width and the bench completion timeout.
package stein_pkg;
  localparam int STEIN_W       = 8;
  localparam int STEIN_TIMEOUT = 200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    REDUCE = 3'd2,
    LOOP   = 3'd3,
    FINISH = 3'd4
  } state_e;
endpackage

// File: rtl/stein_halve_mod.sv
// Modular halving: y = x/2 mod q for odd q, using (x+q)>>1 when x is odd.
module stein_halve_mod
  import stein_pkg::*;
#(
  parameter int W = STEIN_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);
  logic [W:0] sum;

  always_comb begin
    sum = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    y   = W'(sum >> 1);
  end
endmodule

// File: rtl/stein_mod_inverse.sv
// Clocked binary extended-GCD engine computing R = P^-1 mod Q with start/done handshake.
// Optional cycle counter output enabled by defining STEIN_INV_CYCLES_EN.
module stein_mod_inverse
  import stein_pkg::*;
#(
  parameter int W = STEIN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] P,
  input  logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         valid,
  output logic         busy,
  output state_e       state_dbg,
  output logic         done
`ifdef STEIN_INV_CYCLES_EN
  , output logic [15:0] cycles
`endif
);
  // Handshake: start is a one-cycle request honoured only in IDLE; busy covers
  // CHECK..LOOP; done pulses in FINISH, the cycle in which R/valid first show the result.
  state_e       state_q, state_d;
  logic [W-1:0] p_q, p_d, q_q, q_d;
  logic [W-1:0] u_q, u_d, v_q, v_d;
  logic [W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [W-1:0] r_q, r_d;
  logic         valid_q, valid_d;
  logic [W-1:0] x1_half, x2_half;
  logic [W:0]   x1_sub, x2_sub;

  stein_halve_mod #(.W(W)) u_halve_x1 (.x(x1_q), .q(q_q), .y(x1_half));
  stein_halve_mod #(.W(W)) u_halve_x2 (.x(x2_q), .q(q_q), .y(x2_half));

  // Differences are taken mod q, wrapping through q when they would go negative.
  always_comb begin
    x1_sub = (x1_q >= x2_q) ? ({1'b0, x1_q} - {1'b0, x2_q})
                            : ({1'b0, x1_q} + {1'b0, q_q} - {1'b0, x2_q});
    x2_sub = (x2_q >= x1_q) ? ({1'b0, x2_q} - {1'b0, x1_q})
                            : ({1'b0, x2_q} + {1'b0, q_q} - {1'b0, x1_q});
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    r_d     = r_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = P;
          q_d     = Q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!q_q[0] || (q_q < W'(3))) begin
          r_d     = '0;
          valid_d = 1'b0;
          state_d = FINISH;
        end else begin
          u_d     = p_q;
          v_d     = q_q;
          x1_d    = W'(1);
          x2_d    = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (u_q >= q_q) u_d = u_q - q_q;
        else            state_d = LOOP;
      end
      LOOP: begin
        if (u_q == W'(1)) begin
          r_d     = x1_q;
          valid_d = 1'b1;
          state_d = FINISH;
        end else if (v_q == W'(1)) begin
          r_d     = x2_q;
          valid_d = 1'b1;
          state_d = FINISH;
        end else if (u_q == '0) begin
          r_d     = '0;
          valid_d = 1'b0;
          state_d = FINISH;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = W'(x1_sub);
        end else begin
          v_d  = v_q - u_q;
          x2_d = W'(x2_sub);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      r_q     <= r_d;
      valid_q <= valid_d;
    end
  end

  assign R         = r_q;
  assign valid     = valid_q;
  assign busy      = (state_q == CHECK) || (state_q == REDUCE) || (state_q == LOOP);
  assign done      = (state_q == FINISH);
  assign state_dbg = state_q;

`ifdef STEIN_INV_CYCLES_EN
  logic [15:0] cnt_q, cnt_d, cycles_q, cycles_d;

  // cnt_q is zero on CHECK entry, so cnt_q+1 in FINISH counts CHECK..FINISH inclusive.
  always_comb begin
    cnt_d    = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
    cycles_d = (state_q == FINISH) ? cnt_q + 16'd1 : cycles_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif
endmodule
